// File: rtl/wb_pkg.sv
// Shared defaults and the queue entry type for the writeback arbiter.
package wb_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DEPTH  = 2;

   // One queued register write at the default widths.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small shift-style FIFO: slot 0 is always the head, slots [0..count-1] are valid.
// When empty, the head presents the incoming push so it can be popped the same
// cycle without ever being stored.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [ADDR_W-1:0]              push_addr,
   input  logic [DATA_W-1:0]              push_data,
   input  logic                           pop,
   output logic [CW-1:0]                  count,
   output logic                           head_valid,
   output logic [ADDR_W-1:0]              head_addr,
   output logic [DATA_W-1:0]              head_data,
   output logic [DEPTH-1:0]               ent_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr
);

   logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_n;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_n;
   logic [CW-1:0]                wr_idx;
   logic                         empty;

   assign empty      = (count == '0);
   assign head_valid = !empty || push;
   assign head_addr  = empty ? push_addr : addr_q[0];
   assign head_data  = empty ? push_data : data_q[0];
   assign ent_addr   = addr_q;
   // a pop from a non-empty queue frees the slot below the current tail
   assign wr_idx     = count - CW'(pop);

   // per-slot valid flags for the hazard compare in the parent
   always_comb begin
      ent_valid = '0;
      for (int i = 0; i < DEPTH; i++)
         ent_valid[i] = (CW'(i) < count);
   end

   // next slot contents: shift on pop, then place the push at the new tail
   always_comb begin
      addr_n = addr_q;
      data_n = data_q;
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            addr_n[i] = addr_q[i+1];
            data_n[i] = data_q[i+1];
         end
      end
      // push-and-pop on an empty queue is a straight bypass, nothing is stored
      if (push && !(pop && empty)) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx == CW'(i)) begin
               addr_n[i] = push_addr;
               data_n[i] = push_data;
            end
         end
      end
   end

   // occupancy counter
   always_ff @(posedge clk) begin
      if (!rst_n) count <= '0;
      else        count <= count + CW'(push) - CW'(pop);
   end

   // slot storage; contents are qualified by count so they need no reset
   always_ff @(posedge clk) begin
      addr_q <= addr_n;
      data_q <= data_n;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and memory-load writebacks into one register-file write port.
// Each source queues into its own FIFO; one head per cycle moves to the
// registered output stage, with round-robin on contention. A source is held
// off while its address is still queued on the other side so that writes to
// the same register never reorder across sources.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [ADDR_W-1:0]     alu_addr,
   input  logic [DATA_W-1:0]     alu_data,
   output logic                  alu_ready,
   input  logic                  mem_valid,
   input  logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_data,
   output logic                  mem_ready,
   output logic                  rf_we,
   output logic [ADDR_W-1:0]     rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic [2**ADDR_W-1:0]  pending_mask,
   output logic                  busy
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]                alu_cnt, mem_cnt;
   logic                         alu_hv, mem_hv;
   logic [ADDR_W-1:0]            alu_ha, mem_ha;
   logic [DATA_W-1:0]            alu_hd, mem_hd;
   logic [DEPTH-1:0]             alu_ev, mem_ev;
   logic [DEPTH-1:0][ADDR_W-1:0] alu_ea, mem_ea;
   logic alu_push, mem_push, alu_pop, mem_pop;
   logic alu_hit, mem_hit, alu_ok, mem_ok, same_addr;
   logic rr_mem;   // 1: memory source wins the next contention
   logic [2**ADDR_W-1:0] pm;

   wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_q (
      .clk(clk), .rst_n(rst_n), .push(alu_push), .push_addr(alu_addr),
      .push_data(alu_data), .pop(alu_pop), .count(alu_cnt), .head_valid(alu_hv),
      .head_addr(alu_ha), .head_data(alu_hd), .ent_valid(alu_ev), .ent_addr(alu_ea)
   );

   wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_q (
      .clk(clk), .rst_n(rst_n), .push(mem_push), .push_addr(mem_addr),
      .push_data(mem_data), .pop(mem_pop), .count(mem_cnt), .head_valid(mem_hv),
      .head_addr(mem_ha), .head_data(mem_hd), .ent_valid(mem_ev), .ent_addr(mem_ea)
   );

   // cross-queue address hazard: a request waits while the other queue holds its register
   always_comb begin
      alu_hit = 1'b0;
      mem_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_ev[i] && mem_ea[i] == alu_addr) alu_hit = 1'b1;
         if (alu_ev[i] && alu_ea[i] == mem_addr) mem_hit = 1'b1;
      end
   end

   // readiness ignores same-cycle pops so ready has no path through arbitration
   assign alu_ok    = rst_n && (alu_cnt < CW'(DEPTH)) && !alu_hit;
   assign mem_ok    = rst_n && (mem_cnt < CW'(DEPTH)) && !mem_hit;
   // same register requested by both at once: memory goes first, ALU retries
   assign same_addr = alu_valid && mem_valid && (alu_addr == mem_addr) && mem_ok;
   assign alu_ready = alu_ok && !same_addr;
   assign mem_ready = mem_ok;
   assign alu_push  = alu_valid && alu_ready;
   assign mem_push  = mem_valid && mem_ready;

   // pick one head per cycle; round-robin only matters when both are present
   always_comb begin
      alu_pop = 1'b0;
      mem_pop = 1'b0;
      if (alu_hv && mem_hv) begin
         if (rr_mem) mem_pop = 1'b1;
         else        alu_pop = 1'b1;
      end else if (alu_hv) begin
         alu_pop = 1'b1;
      end else if (mem_hv) begin
         mem_pop = 1'b1;
      end
   end

   // round-robin pointer, moved only by a contended grant
   always_ff @(posedge clk) begin
      if (!rst_n)              rr_mem <= 1'b0;
      else if (alu_hv && mem_hv) rr_mem <= alu_pop;
   end

   // output stage; address and data hold when nothing is popped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= alu_pop || mem_pop;
         if (alu_pop) begin
            rf_waddr <= alu_ha;
            rf_wdata <= alu_hd;
         end else if (mem_pop) begin
            rf_waddr <= mem_ha;
            rf_wdata <= mem_hd;
         end
      end
   end

   // registers with a write still in flight: queued entries plus the output stage
   always_comb begin
      pm = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_ev[i]) pm[alu_ea[i]] = 1'b1;
         if (mem_ev[i]) pm[mem_ea[i]] = 1'b1;
      end
      if (rf_we) pm[rf_waddr] = 1'b1;
   end

   assign pending_mask = rst_n ? pm : '0;
   assign busy         = rst_n && ((alu_cnt != '0) || (mem_cnt != '0) || rf_we);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a table of hand-derived cycles covering the
// directed scenarios, then randomized traffic against a queue-level model.
module tb_writeback_arbiter;
   import wb_pkg::*;

   localparam int DW = 64;
   localparam int AW = 4;
   localparam int D  = 2;

   logic           clk, rst_n;
   logic           alu_valid, alu_ready, mem_valid, mem_ready;
   logic [AW-1:0]  alu_addr, mem_addr, rf_waddr;
   logic [DW-1:0]  alu_data, mem_data, rf_wdata;
   logic           rf_we, busy;
   logic [15:0]    pending_mask;

   int n_vec = 0;
   int n_err = 0;

   writeback_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pending_mask(pending_mask), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   typedef struct {
      logic rst, av; logic [3:0] aa; logic [63:0] ad;
      logic mv;      logic [3:0] ma; logic [63:0] md;
      logic chk_rf;
      logic ar, mr, we; logic [3:0] wa; logic [63:0] wd; logic [15:0] pm; logic bsy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic av, logic [3:0] aa, logic [63:0] ad,
                               logic mv, logic [3:0] ma, logic [63:0] md, logic chk_rf,
                               logic ar, logic mr, logic we, logic [3:0] wa,
                               logic [63:0] wd, logic [15:0] pm, logic bsy);
      vec_t v;
      v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
      v.chk_rf = chk_rf; v.ar = ar; v.mr = mr; v.we = we; v.wa = wa; v.wd = wd;
      v.pm = pm; v.bsy = bsy;
      return v;
   endfunction

   task automatic drive(input logic r, input logic av, input logic [3:0] aa, input logic [63:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [63:0] md);
      rst_n = r; alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // queue-level reference model
   wb_entry_t qa[$], qm[$];
   logic          m_rr;   // next contention goes to memory
   logic          m_we;
   logic [3:0]    m_wa;
   logic [63:0]   m_wd;

   function automatic logic hit(input wb_entry_t q[$], input logic [3:0] a);
      foreach (q[i]) if (q[i].addr == a) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      // rst av aa ad  mv ma md  chk | ar mr we wa wd pm busy
      tbl.push_back(mk(0,1,3,0,     1,5,0,     1, 0,0,0,0,0,     16'h0000,0)); // 0 held in reset
      tbl.push_back(mk(1,1,3,'hAA,  0,0,0,     1, 1,1,0,0,0,     16'h0000,0)); // 1 single ALU write
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,3,'hAA,  16'h0008,0|1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,3,'hAA,  16'h0000,0));
      tbl.push_back(mk(1,1,1,'h101, 1,5,'h505, 1, 1,1,0,3,'hAA,  16'h0000,0)); // 4 contention 1,5,2,6
      tbl.push_back(mk(1,1,2,'h102, 1,6,'h506, 1, 1,1,1,1,'h101, 16'h0022,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,5,'h505, 16'h0064,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,2,'h102, 16'h0044,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,6,'h506, 16'h0040,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,6,'h506, 16'h0000,0));
      tbl.push_back(mk(1,1,8,'h88,  1,9,'h99,  1, 1,1,0,6,'h506, 16'h0000,0)); // 10 hazard on 7
      tbl.push_back(mk(1,0,0,0,     1,7,'h77,  1, 1,1,1,9,'h99,  16'h0300,1));
      tbl.push_back(mk(1,1,7,'h7A,  0,0,0,     1, 0,1,1,8,'h88,  16'h0180,1));
      tbl.push_back(mk(1,1,7,'h7A,  0,0,0,     1, 1,1,1,7,'h77,  16'h0080,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,7,'h7A,  16'h0080,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,7,'h7A,  16'h0000,0));
      tbl.push_back(mk(1,1,4,'h11,  1,4,'h22,  1, 0,1,0,7,'h7A,  16'h0000,0)); // 16 same address
      tbl.push_back(mk(1,1,4,'h11,  0,0,0,     1, 1,1,1,4,'h22,  16'h0010,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,4,'h11,  16'h0010,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,4,'h11,  16'h0000,0));
      tbl.push_back(mk(1,1,1,'hA1,  1,8,'hB1,  1, 1,1,0,4,'h11,  16'h0000,0)); // 20 ALU queue fills
      tbl.push_back(mk(1,1,2,'hA2,  1,9,'hB2,  1, 1,1,1,8,'hB1,  16'h0102,1));
      tbl.push_back(mk(1,1,3,'hA3,  1,10,'hB3, 1, 1,1,1,1,'hA1,  16'h0206,1));
      tbl.push_back(mk(1,1,4,'hA4,  0,0,0,     1, 0,1,1,9,'hB2,  16'h060C,1));
      tbl.push_back(mk(1,1,4,'hA4,  0,0,0,     1, 1,1,1,2,'hA2,  16'h040C,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 0,1,1,10,'hB3, 16'h0418,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,3,'hA3,  16'h0018,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,1,4,'hA4,  16'h0010,1));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,4,'hA4,  16'h0000,0));
      tbl.push_back(mk(1,1,1,'hC1,  1,5,'hD1,  1, 1,1,0,4,'hA4,  16'h0000,0)); // 29 reset mid-stream
      tbl.push_back(mk(1,1,2,'hC2,  1,6,'hD2,  1, 1,1,1,1,'hC1,  16'h0022,1));
      tbl.push_back(mk(1,1,3,'hC3,  1,7,'hD3,  1, 1,1,1,5,'hD1,  16'h0064,1));
      tbl.push_back(mk(0,1,4,'hE4,  1,8,'hE8,  0, 0,0,0,0,0,     16'h0000,0));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,0,0,     16'h0000,0));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,0,0,     16'h0000,0));
      tbl.push_back(mk(1,0,0,0,     0,0,0,     1, 1,1,0,0,0,     16'h0000,0));

      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);

      foreach (tbl[k]) begin
         @(negedge clk);
         drive(tbl[k].rst, tbl[k].av, tbl[k].aa, tbl[k].ad, tbl[k].mv, tbl[k].ma, tbl[k].md);
         #1;
         chk($sformatf("row%0d alu_ready", k), 64'(alu_ready), 64'(tbl[k].ar));
         chk($sformatf("row%0d mem_ready", k), 64'(mem_ready), 64'(tbl[k].mr));
         chk($sformatf("row%0d pending_mask", k), 64'(pending_mask), 64'(tbl[k].pm));
         chk($sformatf("row%0d busy", k), 64'(busy), 64'(tbl[k].bsy));
         if (tbl[k].chk_rf) begin
            chk($sformatf("row%0d rf_we", k), 64'(rf_we), 64'(tbl[k].we));
            chk($sformatf("row%0d rf_waddr", k), 64'(rf_waddr), 64'(tbl[k].wa));
            chk($sformatf("row%0d rf_wdata", k), rf_wdata, tbl[k].wd);
         end
      end

      // the table ends in a freshly reset, idle state with no contention since
      m_rr = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;

      for (int c = 0; c < 500; c++) begin
         logic r, av, mv, a_ok, m_ok, e_ar, e_mr, e_busy, take_a, take_m, both;
         logic [3:0] aa, ma;
         logic [63:0] ad, md;
         logic [15:0] e_pm;
         wb_entry_t e;
         @(negedge clk);
         r  = ($urandom_range(0, 49) != 0);
         av = ($urandom_range(0, 9) < 6);
         mv = ($urandom_range(0, 9) < 6);
         aa = 4'($urandom_range(0, 7));
         ma = 4'($urandom_range(0, 7));
         ad = {$urandom, $urandom};
         md = {$urandom, $urandom};
         drive(r, av, aa, ad, mv, ma, md);
         #1;
         a_ok = r && (qa.size() < D) && !hit(qm, aa);
         m_ok = r && (qm.size() < D) && !hit(qa, ma);
         e_mr = m_ok;
         e_ar = a_ok && !(av && mv && (aa == ma) && m_ok);
         e_pm = '0;
         foreach (qa[i]) e_pm[qa[i].addr] = 1'b1;
         foreach (qm[i]) e_pm[qm[i].addr] = 1'b1;
         if (m_we) e_pm[m_wa] = 1'b1;
         e_busy = (qa.size() != 0) || (qm.size() != 0) || m_we;
         if (!r) begin e_pm = '0; e_busy = 1'b0; end
         chk($sformatf("rnd%0d alu_ready", c), 64'(alu_ready), 64'(e_ar));
         chk($sformatf("rnd%0d mem_ready", c), 64'(mem_ready), 64'(e_mr));
         chk($sformatf("rnd%0d rf_we", c), 64'(rf_we), 64'(m_we));
         chk($sformatf("rnd%0d rf_waddr", c), 64'(rf_waddr), 64'(m_wa));
         chk($sformatf("rnd%0d rf_wdata", c), rf_wdata, m_wd);
         chk($sformatf("rnd%0d pending_mask", c), 64'(pending_mask), 64'(e_pm));
         chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(e_busy));
         @(posedge clk);
         if (!r) begin
            qa.delete(); qm.delete();
            m_rr = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
         end else begin
            if (av && e_ar) qa.push_back('{addr: aa, data: ad});
            if (mv && e_mr) qm.push_back('{addr: ma, data: md});
            both   = (qa.size() != 0) && (qm.size() != 0);
            take_a = (qa.size() != 0) && ((qm.size() == 0) || !m_rr);
            take_m = !take_a && (qm.size() != 0);
            if (both) m_rr = take_a;
            m_we = take_a || take_m;
            if (take_a) begin
               e = qa.pop_front(); m_wa = e.addr; m_wd = e.data;
            end else if (take_m) begin
               e = qm.pop_front(); m_wa = e.addr; m_wd = e.data;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
